// File: rtl/weapons_control_unit_mc_if.sv
// Status/command bus between targeting, the weapons control unit and the launcher drivers.
// master: drives the command inputs (targeting side); slave: the control unit itself.
interface weapons_control_unit_mc_if #(
    parameter int unsigned NUM_LAUNCHERS = 2,
    parameter int unsigned CNT_W         = 4
) ();
    logic                     target_locked;
    logic                     fire_command;
    logic                     salvo_mode;
    logic                     reload_req;
    logic [NUM_LAUNCHERS-1:0] launch_missile;
    logic [CNT_W-1:0]         remaining_missiles;
    logic [1:0]               WCU_state;

    modport master (
        output target_locked, fire_command, salvo_mode, reload_req,
        input  launch_missile, remaining_missiles, WCU_state
    );

    modport slave (
        input  target_locked, fire_command, salvo_mode, reload_req,
        output launch_missile, remaining_missiles, WCU_state
    );
endinterface

// File: rtl/weapons_control_unit_mc.sv
// Multi-launcher weapons control unit: lock/fire FSM, round-robin single shots, timed reload.
// Optional salvo firing is compiled in with the macro WCU_SALVO_EN; without it salvo_mode is
// ignored and every shot is single-shot.
module weapons_control_unit_mc #(
    parameter int unsigned NUM_LAUNCHERS = 2,
    parameter int unsigned MAG_DEPTH     = 4,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned RELOAD_CYCLES = 3
) (
    input logic                      clk,
    input logic                      rst,   // synchronous, active-low
    weapons_control_unit_mc_if.slave bus
);
    localparam int unsigned MagW = $clog2(MAG_DEPTH + 1);
    localparam int unsigned PtrW = (NUM_LAUNCHERS > 1) ? $clog2(NUM_LAUNCHERS) : 1;
    localparam logic [MagW-1:0]  MagFull  = MagW'(MAG_DEPTH);
    localparam logic [CNT_W-1:0] Capacity = CNT_W'(NUM_LAUNCHERS * MAG_DEPTH);
    localparam logic [7:0]       RldLast  = 8'(RELOAD_CYCLES - 1);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NUM_LAUNCHERS - 1);
    localparam logic [PtrW:0]    NumL     = (PtrW + 1)'(NUM_LAUNCHERS);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLocked = 2'b01,
        StFire   = 2'b10,
        StReload = 2'b11
    } state_e;

    state_e                   state_q, state_d;
    logic [MagW-1:0]          mag_q [NUM_LAUNCHERS];
    logic [MagW-1:0]          mag_d [NUM_LAUNCHERS];
    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [NUM_LAUNCHERS-1:0] launch_q, launch_d;
    logic [7:0]               rld_cnt_q, rld_cnt_d;

    logic [CNT_W-1:0] remaining;
    logic             salvo_en;
    logic             fire_go, reload_go, reload_done;
    logic             sel_found;
    logic [PtrW-1:0]  sel_idx;
    logic [PtrW:0]    probe;

`ifdef WCU_SALVO_EN
    assign salvo_en = bus.salvo_mode;
`else
    assign salvo_en = 1'b0;
`endif

    // Total missiles across all magazines
    always_comb begin
        remaining = '0;
        for (int i = 0; i < NUM_LAUNCHERS; i++) begin
            remaining = remaining + CNT_W'(mag_q[i]);
        end
    end

    // Decode the events that move both the FSM and the datapath
    always_comb begin
        fire_go     = (state_q == StLocked) && bus.target_locked && bus.fire_command &&
                      (remaining != '0);
        reload_go   = (state_q == StIdle) && !bus.target_locked && bus.reload_req &&
                      (remaining < Capacity);
        reload_done = (state_q == StReload) && (rld_cnt_q == RldLast);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            launch_q  <= '0;
            rld_cnt_q <= '0;
            for (int i = 0; i < NUM_LAUNCHERS; i++) begin
                mag_q[i] <= MagFull;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            launch_q  <= launch_d;
            rld_cnt_q <= rld_cnt_d;
            for (int i = 0; i < NUM_LAUNCHERS; i++) begin
                mag_q[i] <= mag_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.target_locked) state_d = StLocked;
                else if (reload_go)    state_d = StReload;
            end
            StLocked: begin
                if (!bus.target_locked) state_d = StIdle;
                else if (fire_go)       state_d = StFire;
            end
            // remaining already reflects the shot just taken
            StFire: begin
                if (remaining == '0)       state_d = StIdle;
                else if (bus.target_locked) state_d = StLocked;
                else                        state_d = StIdle;
            end
            StReload: begin
                if (reload_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // First non-empty launcher at or after ptr, with wrap-around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int k = 0; k < NUM_LAUNCHERS; k++) begin
            probe = {1'b0, ptr_q} + (PtrW + 1)'(k);
            if (probe >= NumL) probe = probe - NumL;
            if (!sel_found && (mag_q[probe[PtrW-1:0]] != '0)) begin
                sel_found = 1'b1;
                sel_idx   = probe[PtrW-1:0];
            end
        end
    end

    // Magazine, pointer, launch strobe and reload counter updates
    always_comb begin
        ptr_d     = ptr_q;
        launch_d  = '0;
        rld_cnt_d = rld_cnt_q;
        for (int i = 0; i < NUM_LAUNCHERS; i++) begin
            mag_d[i] = mag_q[i];
        end

        if (reload_go) rld_cnt_d = '0;
        else if (state_q == StReload) rld_cnt_d = rld_cnt_q + 8'd1;

        if (reload_done) begin
            for (int i = 0; i < NUM_LAUNCHERS; i++) begin
                mag_d[i] = MagFull;
            end
        end

        if (fire_go) begin
            if (salvo_en) begin
                for (int i = 0; i < NUM_LAUNCHERS; i++) begin
                    if (mag_q[i] != '0) begin
                        launch_d[i] = 1'b1;
                        mag_d[i]    = mag_q[i] - 1'b1;
                    end
                end
            end else if (sel_found) begin
                launch_d[sel_idx] = 1'b1;
                mag_d[sel_idx]    = mag_q[sel_idx] - 1'b1;
                ptr_d             = (sel_idx == PtrLast) ? '0 : sel_idx + 1'b1;
            end
        end
    end

    // Outputs to the status bus and launcher drivers
    always_comb begin
        bus.WCU_state          = state_q;
        bus.launch_missile     = launch_q;
        bus.remaining_missiles = remaining;
    end
endmodule

// File: tb/tb_weapons_control_unit_mc.sv
// Self-checking bench for weapons_control_unit_mc: directed scenarios with literal expectations
// plus a randomized run compared against a behavioural model of the lock/fire/reload rules.
module tb_weapons_control_unit_mc;
    localparam int NL = 2;
    localparam int MD = 4;
    localparam int CW = 4;
    localparam int RC = 3;
`ifdef WCU_SALVO_EN
    localparam bit SalvoOn = 1'b1;
`else
    localparam bit SalvoOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    weapons_control_unit_mc_if #(.NUM_LAUNCHERS(NL), .CNT_W(CW)) bus ();

    weapons_control_unit_mc #(
        .NUM_LAUNCHERS(NL),
        .MAG_DEPTH    (MD),
        .CNT_W        (CW),
        .RELOAD_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 idle, 1 locked, 2 fire, 3 reload
    int          m_state = 0;
    int          m_mag[NL];
    int          m_ptr = 0;
    int          m_rcnt = 0;
    logic [NL-1:0] m_launch = '0;

    function automatic int msum();
        int s = 0;
        for (int i = 0; i < NL; i++) s += m_mag[i];
        return s;
    endfunction

    task automatic set_in(input bit tl, input bit fc, input bit rr, input bit sv);
        bus.target_locked = tl;
        bus.fire_command  = fc;
        bus.reload_req    = rr;
        bus.salvo_mode    = sv;
    endtask

    // Advance one clock: evaluate the model on the inputs present at the edge, then commit.
    task automatic tick();
        int n_state, n_ptr, n_rcnt, rem, j;
        int n_mag[NL];
        logic [NL-1:0] n_launch;
        bit done;
        rem = msum();
        n_state = m_state; n_ptr = m_ptr; n_rcnt = m_rcnt; n_launch = '0;
        for (int i = 0; i < NL; i++) n_mag[i] = m_mag[i];
        if (!rst) begin
            n_state = 0; n_ptr = 0; n_rcnt = 0;
            for (int i = 0; i < NL; i++) n_mag[i] = MD;
        end else begin
            case (m_state)
                0: begin
                    if (bus.target_locked) n_state = 1;
                    else if (bus.reload_req && rem < NL * MD) begin
                        n_state = 3; n_rcnt = 0;
                    end
                end
                1: begin
                    if (!bus.target_locked) n_state = 0;
                    else if (bus.fire_command && rem > 0) begin
                        n_state = 2;
                        if (SalvoOn && bus.salvo_mode) begin
                            for (int i = 0; i < NL; i++)
                                if (m_mag[i] > 0) begin
                                    n_mag[i]--; n_launch |= NL'(1) << i;
                                end
                        end else begin
                            done = 1'b0;
                            for (int k = 0; k < NL; k++) begin
                                j = (m_ptr + k) % NL;
                                if (!done && m_mag[j] > 0) begin
                                    done = 1'b1; n_mag[j]--; n_launch = NL'(1) << j;
                                    n_ptr = (j + 1) % NL;
                                end
                            end
                        end
                    end
                end
                2: n_state = (rem == 0) ? 0 : (bus.target_locked ? 1 : 0);
                default: begin
                    n_rcnt = m_rcnt + 1;
                    if (n_rcnt == RC) begin
                        n_state = 0;
                        for (int i = 0; i < NL; i++) n_mag[i] = MD;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        m_state = n_state; m_ptr = n_ptr; m_rcnt = n_rcnt; m_launch = n_launch;
        for (int i = 0; i < NL; i++) m_mag[i] = n_mag[i];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        checks++;
        if (bus.WCU_state !== 2'b00) begin
            errors++; $display("FAIL reset_state got %0b want 00", bus.WCU_state);
        end
        checks++;
        if (bus.remaining_missiles !== 4'd8) begin
            errors++; $display("FAIL reset_remaining got %0d want 8", bus.remaining_missiles);
        end
        checks++;
        if (bus.launch_missile !== 2'b00) begin
            errors++; $display("FAIL reset_launch got %0b want 00", bus.launch_missile);
        end
    endtask

    task automatic test_single_shot();
        logic [1:0] exp_l[2] = '{2'b01, 2'b10};
        logic [3:0] exp_r[2] = '{4'd7, 4'd6};
        set_in(1, 0, 0, 0);
        tick();
        for (int s = 0; s < 2; s++) begin
            set_in(1, 1, 0, 0);
            tick();
            checks++;
            if (bus.WCU_state !== 2'b10 || bus.launch_missile !== exp_l[s] ||
                bus.remaining_missiles !== exp_r[s]) begin
                errors++;
                $display("FAIL shot%0d got state %0b launch %0b rem %0d want 10 %0b %0d", s,
                         bus.WCU_state, bus.launch_missile, bus.remaining_missiles,
                         exp_l[s], exp_r[s]);
            end
            set_in(1, 0, 0, 0);
            tick();
            checks++;
            if (bus.WCU_state !== 2'b01 || bus.launch_missile !== 2'b00) begin
                errors++;
                $display("FAIL shot%0d_after got state %0b launch %0b want 01 00", s,
                         bus.WCU_state, bus.launch_missile);
            end
        end
    endtask

    // Continues from two shots already taken
    task automatic test_depletion();
        int launches = 2;
        int budget = 40;
        set_in(1, 1, 0, 0);
        while (launches < 8 && budget > 0) begin
            tick();
            budget--;
            if (m_launch != '0) launches++;
            checks++;
            if (bus.launch_missile !== m_launch || bus.WCU_state !== 2'(m_state)) begin
                errors++;
                $display("FAIL deplete_step got launch %0b state %0b want %0b %0d",
                         bus.launch_missile, bus.WCU_state, m_launch, m_state);
            end
        end
        checks++;
        if (launches != 8) begin
            errors++; $display("FAIL deplete_budget got %0d launches want 8", launches);
        end
        tick();
        checks++;
        if (bus.WCU_state !== 2'b00 || bus.remaining_missiles !== 4'd0) begin
            errors++;
            $display("FAIL deplete_empty got state %0b rem %0d want 00 0", bus.WCU_state,
                     bus.remaining_missiles);
        end
        tick();
        tick();
        checks++;
        if (bus.WCU_state !== 2'b01 || bus.launch_missile !== 2'b00) begin
            errors++;
            $display("FAIL deplete_refire got state %0b launch %0b want 01 00", bus.WCU_state,
                     bus.launch_missile);
        end
    endtask

    task automatic test_salvo();
        logic [1:0] want_l = SalvoOn ? 2'b11 : 2'b01;
        logic [3:0] want_r = SalvoOn ? 4'd6 : 4'd7;
        do_reset();
        set_in(1, 0, 0, 1);
        tick();
        set_in(1, 1, 0, 1);
        tick();
        checks++;
        if (bus.launch_missile !== want_l || bus.remaining_missiles !== want_r) begin
            errors++;
            $display("FAIL salvo got launch %0b rem %0d want %0b %0d", bus.launch_missile,
                     bus.remaining_missiles, want_l, want_r);
        end
        set_in(1, 0, 0, 0);
        tick();
    endtask

    task automatic test_reload();
        do_reset();
        set_in(1, 0, 0, 0);
        tick();
        for (int s = 0; s < 3; s++) begin
            set_in(1, 1, 0, 0); tick();
            set_in(1, 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0);
        tick();
        checks++;
        if (bus.WCU_state !== 2'b00 || bus.remaining_missiles !== 4'd5) begin
            errors++;
            $display("FAIL reload_pre got state %0b rem %0d want 00 5", bus.WCU_state,
                     bus.remaining_missiles);
        end
        set_in(0, 0, 1, 0);
        tick();
        for (int c = 0; c < RC; c++) begin
            checks++;
            if (bus.WCU_state !== 2'b11 || bus.remaining_missiles !== 4'd5 ||
                bus.launch_missile !== 2'b00) begin
                errors++;
                $display("FAIL reload_cycle%0d got state %0b rem %0d launch %0b want 11 5 00",
                         c, bus.WCU_state, bus.remaining_missiles, bus.launch_missile);
            end
            if (c < RC - 1) set_in(1, 1, 0, 0);
            else set_in(0, 0, 0, 0);
            tick();
        end
        checks++;
        if (bus.WCU_state !== 2'b00 || bus.remaining_missiles !== 4'd8) begin
            errors++;
            $display("FAIL reload_done got state %0b rem %0d want 00 8", bus.WCU_state,
                     bus.remaining_missiles);
        end
        // Lock wins over reload in IDLE even when a reload would be allowed
        set_in(1, 0, 0, 0); tick();
        set_in(1, 1, 0, 0); tick();
        set_in(0, 0, 0, 0); tick();
        set_in(1, 0, 1, 0); tick();
        checks++;
        if (bus.WCU_state !== 2'b01 || bus.remaining_missiles !== 4'd7) begin
            errors++;
            $display("FAIL lock_priority got state %0b rem %0d want 01 7", bus.WCU_state,
                     bus.remaining_missiles);
        end
        set_in(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 1, 0, 0); tick();
        rst = 1'b0;
        set_in(1, 0, 0, 0);
        tick();
        rst = 1'b1;
        checks++;
        if (bus.WCU_state !== 2'b00 || bus.remaining_missiles !== 4'd8 ||
            bus.launch_missile !== 2'b00) begin
            errors++;
            $display("FAIL rst_in_fire got state %0b rem %0d launch %0b want 00 8 00",
                     bus.WCU_state, bus.remaining_missiles, bus.launch_missile);
        end
        tick();
        set_in(1, 1, 0, 0); tick();
        checks++;
        if (bus.launch_missile !== 2'b01) begin
            errors++; $display("FAIL rst_ptr got launch %0b want 01", bus.launch_missile);
        end
        set_in(0, 0, 0, 0); tick();
        set_in(0, 0, 1, 0); tick();
        checks++;
        if (bus.WCU_state !== 2'b11) begin
            errors++; $display("FAIL rst_pre_reload got state %0b want 11", bus.WCU_state);
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        rst = 1'b1;
        checks++;
        if (bus.WCU_state !== 2'b00 || bus.remaining_missiles !== 4'd8 ||
            bus.launch_missile !== 2'b00) begin
            errors++;
            $display("FAIL rst_in_reload got state %0b rem %0d launch %0b want 00 8 00",
                     bus.WCU_state, bus.remaining_missiles, bus.launch_missile);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 39) != 0);
            set_in(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 9) < 2), bit'($urandom_range(0, 1)));
            tick();
            checks++;
            if (bus.WCU_state !== 2'(m_state) || bus.launch_missile !== m_launch ||
                bus.remaining_missiles !== CW'(msum())) begin
                errors++;
                $display("FAIL random%0d got state %0b launch %0b rem %0d want %0d %0b %0d", c,
                         bus.WCU_state, bus.launch_missile, bus.remaining_missiles, m_state,
                         m_launch, msum());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NL; i++) m_mag[i] = MD;
        set_in(0, 0, 0, 0);
        test_reset();
        test_single_shot();
        test_depletion();
        test_salvo();
        test_reload();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
